// File: rtl/mb_sync_arbiter_if.sv
// Bus bundle between source-domain requesters, the
// arbiter and the source side of the multi-bit CDC channel.
interface mb_sync_arbiter_if #(
  parameter int NB   = 8,
  parameter int NREQ = 4
);
  localparam int SW = $clog2(NREQ);

  logic [NREQ-1:0]    i_req;
  logic [NREQ*NB-1:0] i_data;
  logic               i_ack_toggle;
  logic [NB-1:0]      o_data;
  logic               o_req_toggle;
  logic [SW-1:0]      o_sel;
  logic [NREQ-1:0]    o_done;
  logic               o_busy;
  logic               o_timeout;

  modport master (
    output i_req,
    output i_data,
    output i_ack_toggle,
    input  o_data,
    input  o_req_toggle,
    input  o_sel,
    input  o_done,
    input  o_busy,
    input  o_timeout
  );

  modport slave (
    input  i_req,
    input  i_data,
    input  i_ack_toggle,
    output o_data,
    output o_req_toggle,
    output o_sel,
    output o_done,
    output o_busy,
    output o_timeout
  );
endinterface

// File: rtl/mb_sync_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake CDC
// channel; holds data SETTLE_CYC cycles before toggling.
module mb_sync_arbiter #(
  parameter int NB          = 8,
  parameter int NREQ        = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic i_src_clock,
  input  logic i_reset,
  mb_sync_arbiter_if.slave bus
);
  localparam int SW = $clog2(NREQ);
  localparam int TW =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  localparam logic [SW-1:0] PTR_RST = SW'(NREQ - 1);
  localparam logic [7:0] SET_LD = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT_ACK
  } state_t;

  state_t state_q, state_d;

  logic            ack_s1_q, ack_s2_q;
  logic [NB-1:0]   data_q, data_d;
  logic            tog_q, tog_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            to_q, to_d;
  logic [7:0]      scnt_q, scnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;

  logic            found;
  logic [SW-1:0]   win;
  logic            match;
  int              idx;

  assign match = (ack_s2_q == tog_q);

  // Round-robin scan upward from the slot after the pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && bus.i_req[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
  end

  // State and datapath registers, plus the ack synchronizer.
  always_ff @(posedge i_src_clock) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      data_q   <= '0;
      tog_q    <= 1'b0;
      sel_q    <= '0;
      ptr_q    <= PTR_RST;
      done_q   <= '0;
      to_q     <= 1'b0;
      scnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ack_s1_q <= bus.i_ack_toggle;
      ack_s2_q <= ack_s1_q;
      data_q   <= data_d;
      tog_q    <= tog_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      to_q     <= to_d;
      scnt_q   <= scnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Next-state: grant, settle countdown, ack wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (found) state_d = S_SETTLE;
      S_SETTLE:
        if (scnt_q == 8'd0) state_d = S_WAIT_ACK;
      S_WAIT_ACK:
        if (match) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Datapath updates driven by the current state.
  always_comb begin
    data_d = data_q;
    tog_d  = tog_q;
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    done_d = '0;
    to_d   = to_q;
    scnt_d = scnt_q;
    tcnt_d = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d  = win;
          data_d = bus.i_data[int'(win)*NB +: NB];
          scnt_d = SET_LD;
        end
      end
      S_SETTLE: begin
        if (scnt_q == 8'd0) begin
          tog_d  = ~tog_q;
          tcnt_d = '0;
        end else begin
          scnt_d = scnt_q - 8'd1;
        end
      end
      S_WAIT_ACK: begin
        if (match) begin
          done_d[sel_q] = 1'b1;
          ptr_d         = sel_q;
        end else if (TIMEOUT_CYC > 0) begin
          if (tcnt_q != TMAX) tcnt_d = tcnt_q + TW'(1);
          if (tcnt_d == TMAX) to_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_data       = data_q;
  assign bus.o_req_toggle = tog_q;
  assign bus.o_sel        = sel_q;
  assign bus.o_done       = done_q;
  assign bus.o_busy       = (state_q != S_IDLE);
  assign bus.o_timeout    = to_q;
endmodule

// File: tb/tb_mb_sync_arbiter.sv
// Directed bench for mb_sync_arbiter with a 3-flop
// destination loopback that can be overridden.
module tb_mb_sync_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic hold;
  logic ack_force;
  logic [2:0] dly;
  int n_chk = 0;
  int n_err = 0;
  int cyc;
  logic bad;

  mb_sync_arbiter_if #(.NB(8), .NREQ(3)) bus ();

  mb_sync_arbiter #(
    .NB(8), .NREQ(3), .SETTLE_CYC(16), .TIMEOUT_CYC(32)
  ) dut (
    .i_src_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) dly <= '0;
    else     dly <= {dly[1:0], bus.o_req_toggle};
  end

  assign bus.i_ack_toggle = hold ? ack_force : dly[2];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int c);
    c = 0;
    do begin
      tick(1);
      c++;
    end while (bus.o_done == 3'b000 && c < maxc);
  endtask

  task automatic set_word(int k, logic [7:0] w);
    bus.i_data[k*8 +: 8] = w;
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    ack_force = 1'b0;
    bus.i_req = '0;
    bus.i_data = '0;
    tick(3);
    rst = 1'b0;

    chk("rst_data", bus.o_data, 0);
    chk("rst_tog", bus.o_req_toggle, 0);
    chk("rst_sel", bus.o_sel, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_to", bus.o_timeout, 0);

    // single request from requester 1
    set_word(1, 8'hA5);
    bus.i_req = 3'b010;
    tick(1);
    chk("s_data", bus.o_data, 8'hA5);
    chk("s_sel", bus.o_sel, 1);
    chk("s_busy", bus.o_busy, 1);
    tick(15);
    chk("s_tog_hold", bus.o_req_toggle, 0);
    chk("s_data_hold", bus.o_data, 8'hA5);
    tick(1);
    chk("s_tog_flip", bus.o_req_toggle, 1);
    wait_done(40, cyc);
    chk("s_done", bus.o_done, 3'b010);
    chk("s_lat", cyc, 6);
    chk("s_busy_fall", bus.o_busy, 0);
    bus.i_req = 3'b000;
    tick(1);
    chk("s_done_pulse", bus.o_done, 0);
    tick(3);
    chk("s_idle", bus.o_busy, 0);

    // fairness: all three requesting
    do_reset();
    for (int k = 0; k < 3; k++) set_word(k, 8'(8'h10 + k));
    bus.i_req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_done(60, cyc);
      chk("f_done", bus.o_done, 32'(1 << k));
      chk("f_sel", bus.o_sel, k);
      chk("f_data", bus.o_data, 8'h10 + k);
      chk("f_tog", bus.o_req_toggle, (k + 1) % 2);
      bus.i_req[k] = 1'b0;
    end
    tick(3);
    chk("f_idle", bus.o_busy, 0);

    // rotation: 0 stays requesting, 2 joins
    do_reset();
    bus.i_req = 3'b001;
    wait_done(60, cyc);
    chk("r_first", bus.o_done, 3'b001);
    bus.i_req = 3'b101;
    wait_done(60, cyc);
    chk("r_second", bus.o_done, 3'b100);
    bus.i_req = 3'b001;
    wait_done(60, cyc);
    chk("r_third", bus.o_done, 3'b001);
    bus.i_req = 3'b000;

    // data stability
    do_reset();
    set_word(0, 8'h3C);
    bus.i_req = 3'b001;
    tick(1);
    chk("d_grant", bus.o_data, 8'h3C);
    set_word(0, 8'hFF);
    tick(8);
    chk("d_settle", bus.o_data, 8'h3C);
    tick(9);
    set_word(0, 8'h81);
    chk("d_wait", bus.o_data, 8'h3C);
    wait_done(40, cyc);
    chk("d_done", bus.o_data, 8'h3C);
    bus.i_req = 3'b000;
    tick(4);
    chk("d_idle", bus.o_data, 8'h3C);
    set_word(0, 8'h77);
    bus.i_req = 3'b001;
    tick(1);
    chk("d_next", bus.o_data, 8'h77);
    bus.i_req = 3'b000;
    wait_done(40, cyc);
    chk("d_next_done", bus.o_done, 3'b001);

    // timeout with ack held low
    hold = 1'b1;
    ack_force = 1'b0;
    do_reset();
    bus.i_req = 3'b001;
    tick(17);
    chk("t_flip", bus.o_req_toggle, 1);
    bad = 1'b0;
    repeat (31) begin
      tick(1);
      if (bus.o_done != 3'b000) bad = 1'b1;
    end
    chk("t_before", bus.o_timeout, 0);
    tick(1);
    chk("t_set", bus.o_timeout, 1);
    chk("t_nodone", {bad, bus.o_done}, 0);
    bus.i_req = 3'b000;
    ack_force = 1'b1;
    wait_done(10, cyc);
    chk("t_late_done", bus.o_done, 3'b001);
    chk("t_late_lat", cyc, 3);
    chk("t_sticky", bus.o_timeout, 1);
    hold = 1'b0;
    tick(3);
    chk("t_sticky2", bus.o_timeout, 1);

    // reset mid-transfer
    bus.i_req = 3'b010;
    tick(18);
    chk("m_wait", bus.o_busy, 1);
    rst = 1'b1;
    bus.i_req = 3'b000;
    tick(1);
    chk("m_tog", bus.o_req_toggle, 0);
    chk("m_busy", bus.o_busy, 0);
    chk("m_to", bus.o_timeout, 0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      tick(1);
      if (bus.o_done != 3'b000) bad = 1'b1;
    end
    chk("m_nodone", bad, 0);
    set_word(2, 8'h5A);
    bus.i_req = 3'b100;
    wait_done(60, cyc);
    chk("m_after", bus.o_done, 3'b100);
    chk("m_after_d", bus.o_data, 8'h5A);
    bus.i_req = 3'b000;
    tick(2);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule
